uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks (TX now, RX later).
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push port between the bus-side register slice and the UART transmitter.
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] wdata;
  logic                      wvalid;
  logic                      wready;

  modport master (output wdata, output wvalid, input wready);
  modport slave  (input wdata, input wvalid, output wready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; DEPTH must be a power of two.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter, LSB first. Define UART_TX_PARITY_EN to add
// an even-parity bit between the last data bit and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a byte in the FIFO
// START  | start bit (low) for BAUD_DIV cycles
// DATA   | 8 data bits, shift[0] on the line, shift right per bit
// PARITY | even parity of the byte (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high); chains straight into START if a byte waits
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 4167,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  uart_tx_fifo_if.slave                   bus,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int          LW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_state_e               state;
  logic [15:0]               baud_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] head;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      push;
  logic                      pop;
  logic                      bit_end;
`ifdef UART_TX_PARITY_EN
  logic                      parity_bit;
`endif

  assign bus.wready = (fifo_level != LW'(FIFO_DEPTH));
  assign push       = bus.wvalid && bus.wready;
  assign bit_end    = (baud_cnt == '0);
  assign pop        = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && bit_end));

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.wdata),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // tx is derived from the current state, so the line lags the state by one
  // cycle; every bit still lasts exactly BAUD_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= UART_IDLE_LEVEL;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      busy <= (state != IDLE) || (fifo_level != '0);
      case (state)
        IDLE: begin
          tx <= UART_IDLE_LEVEL;
          if (pop) begin
            shift    <= head;
            baud_cnt <= BAUD_LOAD;
            state    <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            shift    <= shift >> 1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= parity_bit;
          if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`endif
        STOP: begin
          tx <= UART_IDLE_LEVEL;
          if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            if (pop) begin
              shift <= head;
              state <= START;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^head;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          tx    <= UART_IDLE_LEVEL;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushes queue expected bytes, a line
// monitor decodes frames from tx and checks them against the queue.
module tb_uart_tx_fifo;

  localparam int BAUD  = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = BAUD * NBITS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_level;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         frames = 0;
  int         push_cyc = 0;
  bit         mon_en = 1'b1;
  logic [7:0] exp_q[$];
  int         starts[$];
  logic       par_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b, input bit expect_out);
    int w = 0;
    bus.wdata  = b;
    bus.wvalid = 1'b1;
    while (!bus.wready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!bus.wready) begin
      fail("push_timeout");
      bus.wvalid = 1'b0;
      return;
    end
    @(negedge clk);
    push_cyc = cyc;
    if (expect_out) exp_q.push_back(b);
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (frames < n) fail("frame_timeout");
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (busy) fail("idle_timeout");
  endtask

  // Line monitor: decode each frame, sampling every cycle of every bit.
  initial begin : monitor
    logic [10:0] bits;
    logic        held;
    int          s;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        s    = cyc;
        held = 1'b1;
        bits = '0;
        for (int k = 0; k < NBITS; k++) begin
          for (int c = 0; c < BAUD; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (c == 0) bits[k] = tx;
            else if (tx !== bits[k]) held = 1'b0;
          end
        end
        starts.push_back(s);
        chk("bit_hold", 32'(held), 32'd1);
        chk("start_bit", 32'(bits[0]), 32'd0);
        chk("stop_bit", 32'(bits[NBITS-1]), 32'd1);
`ifdef UART_TX_PARITY_EN
        par_q.push_back(bits[9]);
        chk("parity_bit", 32'(bits[9]), 32'(^bits[8:1]));
`endif
        if (exp_q.size() == 0) fail("unexpected_frame");
        else chk("frame_data", 32'(bits[8:1]), 32'(exp_q.pop_front()));
        frames++;
      end
    end
  end

  initial begin : stim
    int n;
    int base;
    int w;
    int lows;
    bus.wdata  = '0;
    bus.wvalid = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_wready", 32'(bus.wready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single byte: latency, bit timing, busy release
    push(8'h21, 1'b1);
    n = push_cyc;
    wait_cyc(n + 1);
    chk("tx_before_start", 32'(tx), 32'd1);
    chk("busy_rise", 32'(busy), 32'd1);
    wait_cyc(n + 2);
    chk("tx_latency", 32'(tx), 32'd0);
    chk("level_after_pop", 32'(fifo_level), 32'd0);
    wait_cyc(n + 1 + FRAME);
    chk("busy_last_stop", 32'(busy), 32'd1);
    wait_cyc(n + 2 + FRAME);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("level_end", 32'(fifo_level), 32'd0);
    wait_frames(1, FRAME + 50);
    if (starts.size() >= 1) chk("t1_start_cycle", 32'(starts[0]), 32'(n + 2));

    // "Hi!" back to back
    base = frames;
    push(8'h48, 1'b1);
    n = push_cyc;
    push(8'h69, 1'b1);
    push(8'h21, 1'b1);
    wait_frames(base + 3, 3 * FRAME + 50);
    if (starts.size() >= base + 3) begin
      chk("hi_start_cycle", 32'(starts[base]), 32'(n + 2));
      chk("hi_contig_1", 32'(starts[base+1] - starts[base]), 32'(FRAME));
      chk("hi_contig_2", 32'(starts[base+2] - starts[base+1]), 32'(FRAME));
    end
    wait_idle();

    // fill to full while transmitting; 17th byte waits for the first pop
    base = frames;
    push(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b1);
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_wready", 32'(bus.wready), 32'd0);
    bus.wdata  = 8'h3C;
    bus.wvalid = 1'b1;
    w = 0;
    while (!bus.wready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("held_off", 32'(w > 0), 32'd1);
    chk("full_pop_level", 32'(fifo_level), 32'd15);
    @(negedge clk);
    chk("refill_level", 32'(fifo_level), 32'd16);
    chk("refill_wready", 32'(bus.wready), 32'd0);
    exp_q.push_back(8'h3C);
    bus.wvalid = 1'b0;
    wait_frames(base + 18, 18 * FRAME + 200);
    wait_idle();

    // reset during data bit 3 of 0x55 with another byte queued
    mon_en = 1'b0;
    push(8'h55, 1'b0);
    n = push_cyc;
    push(8'h0F, 1'b0);
    chk("push_pop_level", 32'(fifo_level), 32'd1);
    wait_cyc(n + 15);
    chk("bit2_level", 32'(tx), 32'd1);
    wait_cyc(n + 19);
    chk("bit3_level", 32'(tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_tx", 32'(tx), 32'd1);
    chk("midreset_level", 32'(fifo_level), 32'd0);
    chk("midreset_wready", 32'(bus.wready), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    lows  = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_frame_after_reset", 32'(lows), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);
    mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
    base = par_q.size();
    n    = frames;
    push(8'h21, 1'b1);
    push(8'h07, 1'b1);
    wait_frames(n + 2, 2 * FRAME + 50);
    if (par_q.size() >= base + 2) begin
      chk("parity_0x21", 32'(par_q[base]), 32'd0);
      chk("parity_0x07", 32'(par_q[base+1]), 32'd1);
    end
    if (starts.size() >= n + 2) chk("parity_frame_len", 32'(starts[n+1] - starts[n]), 32'd44);
    wait_idle();
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
